rock_ramp_scheduler: RTL and testbench

- Sequences the amplitude (A) and frequency (F) setpoints of the cradle drive.
- Accepts a target A/F pair from the search logic over a req/ack handshake.
- Walks the drive outputs toward the target one code step at a time, with a mandatory dwell between steps for mechanical safety.
- Pulses done on arrival. Raises err on illegal targets.

---
 rtl/rock_ramp_scheduler_pkg.sv | 23 ++
 rtl/rock_ramp_scheduler_if.sv | 27 ++
 rtl/rock_ramp_scheduler_dwell_timer.sv | 38 +++
 rtl/rock_ramp_scheduler.sv | 126 ++++++++++++
 tb/tb_rock_ramp_scheduler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rock_ramp_scheduler_pkg.sv
// Shared types and default sizing for the cradle-drive A/F ramp scheduler.
package rock_pkg;

    localparam int DEF_W           = 3;
    localparam int DEF_A_MAX       = 7;
    localparam int DEF_F_MAX       = 7;
    localparam int DEF_STEP_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DWELL,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        DEC_A,
        MOV_F,
        INC_A,
        NONE
    } step_sel_t;

endpackage

// File: rtl/rock_ramp_scheduler_if.sv
// Request/setpoint bundle between the search logic (master) and the scheduler (slave).
interface rock_ramp_scheduler_if
    import rock_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         req;
    logic [W-1:0] tgt_A;
    logic [W-1:0] tgt_F;
    logic         abort;
    logic         ack;
    logic         busy;
    logic         done;
    logic [W-1:0] A;
    logic [W-1:0] F;
    logic         err;

    modport master (
        output req, tgt_A, tgt_F, abort,
        input  ack, busy, done, A, F, err
    );

    modport slave (
        input  req, tgt_A, tgt_F, abort,
        output ack, busy, done, A, F, err
    );
endinterface

// File: rtl/rock_ramp_scheduler_dwell_timer.sv
// Load/count-down dwell timer; loaded on every entry to STEP so the STEP cycle
// plus the DWELL cycles span exactly STEP_CYCLES clocks.
module rock_dwell_timer
    import rock_pkg::*;
#(
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    localparam int CW         = $clog2(STEP_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dwell,
    output logic expire
);
    localparam logic [CW-1:0] LOAD_VAL = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = LOAD_VAL;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = dwell && (count_reg == '0);
endmodule

// File: rtl/rock_ramp_scheduler.sv
// Walks the drive A/F setpoints toward a requested target one code per step,
// lowering amplitude first, then moving frequency, then raising amplitude.
module rock_ramp_scheduler
    import rock_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int A_MAX       = DEF_A_MAX,
    parameter int F_MAX       = DEF_F_MAX,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    rock_ramp_scheduler_if.slave  bus
);
    localparam logic [W:0] A_LIM = (W+1)'(A_MAX);
    localparam logic [W:0] F_LIM = (W+1)'(F_MAX);

    state_t       state_reg, state_next;
    logic [W-1:0] a_reg, a_next;
    logic [W-1:0] f_reg, f_next;
    logic [W-1:0] ta_reg, ta_next;
    logic [W-1:0] tf_reg, tf_next;
    logic         err_reg, err_next;
    step_sel_t    step_sel;
    logic         illegal;
    logic         expire;
    logic         timer_load;

    always_comb begin
        if (a_reg > ta_reg) begin
            step_sel = DEC_A;
        end else if (f_reg != tf_reg) begin
            step_sel = MOV_F;
        end else if (a_reg < ta_reg) begin
            step_sel = INC_A;
        end else begin
            step_sel = NONE;
        end
    end

    assign illegal = ({1'b0, bus.tgt_A} > A_LIM) || ({1'b0, bus.tgt_F} > F_LIM);

    // The arrival check happens in a STEP slot with nothing left to apply, so
    // done trails the last change by the same spacing as between changes.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        f_next     = f_reg;
        ta_next    = ta_reg;
        tf_next    = tf_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    ta_next = bus.tgt_A;
                    tf_next = bus.tgt_F;
                    if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        err_next   = 1'b0;
                        state_next = (bus.tgt_A == a_reg && bus.tgt_F == f_reg) ? FIN : STEP;
                    end
                end
            end
            STEP: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = (STEP_CYCLES == 1) ? STEP : DWELL;
                    case (step_sel)
                        DEC_A:   a_next = a_reg - 1'b1;
                        MOV_F:   f_next = (f_reg < tf_reg) ? f_reg + 1'b1 : f_reg - 1'b1;
                        INC_A:   a_next = a_reg + 1'b1;
                        default: state_next = FIN;
                    endcase
                end
            end
            DWELL: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = STEP;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            f_reg     <= '0;
            ta_reg    <= '0;
            tf_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            f_reg     <= f_next;
            ta_reg    <= ta_next;
            tf_reg    <= tf_next;
            err_reg   <= err_next;
        end
    end

    assign timer_load = (state_next == STEP);

    rock_dwell_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .dwell  (state_reg == DWELL),
        .expire (expire)
    );

    assign bus.ack  = (state_reg == IDLE) && reset;
    assign bus.busy = (state_reg == STEP) || (state_reg == DWELL);
    assign bus.done = (state_reg == FIN);
    assign bus.A    = a_reg;
    assign bus.F    = f_reg;
    assign bus.err  = err_reg;
endmodule

// File: tb/tb_rock_ramp_scheduler.sv
// Directed bench for rock_ramp_scheduler with STEP_CYCLES=4, A_MAX=5, F_MAX=6.
module tb_rock_ramp_scheduler;
    localparam int W = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rock_ramp_scheduler_if #(.W(W)) bus();

    rock_ramp_scheduler #(
        .W           (W),
        .A_MAX       (5),
        .F_MAX       (6),
        .STEP_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] tgt_a;
        logic [2:0] tgt_f;
        int         exp_err;
        int         first_a;
        int         first_f;
        int         exp_a;
        int         exp_f;
        int         exp_done;   // cycles after accept edge; -1 = never
    } vec_t;

    vec_t vecs[11];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, done_cyc, last_chg, pa, pf, fa, ff, da, df, limit;
        bit busy_seen, fin;
        check("ack_before_req", int'(bus.ack), 1);
        pa = int'(bus.A);
        pf = int'(bus.F);
        fa = pa;
        ff = pf;
        bus.tgt_A = v.tgt_a;
        bus.tgt_F = v.tgt_f;
        bus.req   = 1'b1;
        tick();
        bus.req   = 1'b0;
        check("err_after_accept", int'(bus.err), v.exp_err);
        cyc       = 0;
        done_cyc  = -1;
        last_chg  = -1;
        busy_seen = 1'b0;
        fin       = 1'b0;
        limit     = (v.exp_done < 0) ? 10 : 60;
        while (!fin) begin
            if (int'(bus.A) != pa || int'(bus.F) != pf) begin
                da = int'(bus.A) - pa;
                df = int'(bus.F) - pf;
                if (da < 0) da = -da;
                if (df < 0) df = -df;
                check("single_code_step", da + df, 1);
                check("step_spacing", cyc, (last_chg < 0) ? 1 : last_chg + 4);
                if (last_chg < 0) begin
                    fa = int'(bus.A);
                    ff = int'(bus.F);
                end
                last_chg = cyc;
                pa = int'(bus.A);
                pf = int'(bus.F);
            end
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("ack_after_done", int'(bus.ack), 1);
                check("done_one_cycle", int'(bus.done), 0);
                fin = 1'b1;
            end else if (cyc >= limit) begin
                fin = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        check("done_cycle", done_cyc, v.exp_done);
        check("first_A", fa, v.first_a);
        check("first_F", ff, v.first_f);
        check("final_A", int'(bus.A), v.exp_a);
        check("final_F", int'(bus.F), v.exp_f);
        check("busy_seen", int'(busy_seen), (v.exp_done > 0) ? 1 : 0);
        $display("vec %0d: tgt=%0d/%0d A=%0d F=%0d err=%0d done_cyc=%0d",
                 idx, v.tgt_a, v.tgt_f, bus.A, bus.F, bus.err, done_cyc);
    endtask

    initial begin
        int done_cnt;
        vec_t v;

        //          tA  tF err fA fF  A  F  done
        vecs[0]  = '{3'd2, 3'd1, 0, 0, 1, 2, 1, 13};
        vecs[1]  = '{3'd3, 3'd5, 0, 2, 2, 3, 5, 21};
        vecs[2]  = '{3'd1, 3'd3, 0, 2, 5, 1, 3, 17};
        vecs[3]  = '{3'd1, 3'd3, 0, 1, 3, 1, 3, 0};
        vecs[4]  = '{3'd0, 3'd0, 0, 0, 3, 0, 0, 17};
        vecs[5]  = '{3'd0, 3'd0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{3'd6, 3'd0, 1, 0, 0, 0, 0, -1};
        vecs[7]  = '{3'd0, 3'd7, 1, 0, 0, 0, 0, -1};
        vecs[8]  = '{3'd5, 3'd6, 0, 0, 1, 5, 6, 45};
        vecs[9]  = '{3'd5, 3'd6, 0, 5, 6, 5, 6, 0};
        vecs[10] = '{3'd0, 3'd0, 0, 4, 6, 0, 0, 45};

        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.tgt_A = '0;
        bus.tgt_F = '0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_A", int'(bus.A), 0);
        check("rst_F", int'(bus.F), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_ack_held", int'(bus.ack), 0);
        reset = 1'b1;
        tick();
        check("rst_ack_released", int'(bus.ack), 1);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort on the second step edge of a 0/0 -> 0/3 ramp.
        bus.tgt_A = 3'd0;
        bus.tgt_F = 3'd3;
        bus.req   = 1'b1;
        tick();
        bus.req   = 1'b0;
        check("abort_busy_c0", int'(bus.busy), 1);
        tick();
        check("abort_F_c1", int'(bus.F), 1);
        tick();
        bus.tgt_A = 3'd5;
        bus.tgt_F = 3'd5;
        bus.req   = 1'b1;
        check("ack_while_busy", int'(bus.ack), 0);
        tick();
        bus.req   = 1'b0;
        tick();
        check("abort_busy_c4", int'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_F_hold", int'(bus.F), 1);
        check("abort_A_hold", int'(bus.A), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_ack", int'(bus.ack), 1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_F_later", int'(bus.F), 1);
        $display("abort: A=%0d F=%0d", bus.A, bus.F);

        v = '{3'd0, 3'd1, 0, 0, 1, 0, 1, 0};
        run_vec(11, v);

        // Asynchronous reset in the middle of a dwell.
        bus.tgt_A = 3'd2;
        bus.tgt_F = 3'd2;
        bus.req   = 1'b1;
        tick();
        bus.req   = 1'b0;
        repeat (6) tick();
        check("pre_reset_A", int'(bus.A), 1);
        check("pre_reset_F", int'(bus.F), 2);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_A", int'(bus.A), 0);
        check("async_rst_F", int'(bus.F), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_done", int'(bus.done), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("post_rst_ack", int'(bus.ack), 1);
        check("post_rst_err", int'(bus.err), 0);
        $display("reset mid-dwell: A=%0d F=%0d ack=%0d", bus.A, bus.F, bus.ack);
        tick();

        v = '{3'd1, 3'd1, 0, 0, 1, 1, 1, 9};
        run_vec(12, v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
